// File: rtl/taito_comm_pkg.sv
// Shared index-decode helpers and control-register bit positions for the CPU mailbox.
// Pure declarations; no logic, no latency, no backpressure.
package taito_comm_pkg;

    // Bit 0 of the data word carries every control flag
    localparam int CTRL_SRST_BIT  = 0;
    localparam int CTRL_IRQEN_BIT = 0;
    localparam int CTRL_AMP_BIT   = 0;
    localparam int CTRL_NMIEN_BIT = 0;

    function automatic int calc_iw(input int slots);
        return $clog2(slots + 2);
    endfunction

    function automatic int idx_status(input int slots);
        return slots;
    endfunction

    function automatic int idx_ctrl(input int slots);
        return slots + 1;
    endfunction

endpackage

// File: rtl/taito_comm_mailbox_if.sv
// CPU-side bus of the mailbox: per-side address bit, read/write strobes and data.
// Strobes are single-cycle; no backpressure, read data returns one cycle later.
interface taito_comm_mailbox_if #(
    parameter int DW = 4
);
    logic          M_A0;
    logic          M_RD;
    logic          M_WR;
    logic [DW-1:0] M_DIN;
    logic [DW-1:0] M_DOUT;
    logic          S_A0;
    logic          S_RD;
    logic          S_WR;
    logic [DW-1:0] S_DIN;
    logic [DW-1:0] S_DOUT;

    modport master (
        output M_A0, M_RD, M_WR, M_DIN, S_A0, S_RD, S_WR, S_DIN,
        input  M_DOUT, S_DOUT
    );

    modport slave (
        input  M_A0, M_RD, M_WR, M_DIN, S_A0, S_RD, S_WR, S_DIN,
        output M_DOUT, S_DOUT
    );
endinterface

// File: rtl/comm_port_index.sv
// Per-side auto-incrementing index register plus register-map decode.
// Decode is combinational from the current index; index updates next cycle; no backpressure.
module comm_port_index
    import taito_comm_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int IW    = calc_iw(SLOTS)
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       a0,
    input  logic                       rd,
    input  logic                       wr,
    input  logic [IW-1:0]              din_idx,
    output logic [IW-1:0]              idx,
    output logic [$clog2(SLOTS)-1:0]   slot,
    output logic                       idx_rd,
    output logic                       slot_rd,
    output logic                       slot_wr,
    output logic                       status_rd,
    output logic                       status_wr,
    output logic                       ctrl_rd,
    output logic                       ctrl_wr
);
    logic [IW-1:0] idx_q, idx_d;
    logic          rd_eff;
    logic          in_slots;
    logic          at_status;
    logic          at_ctrl;

    // A simultaneous write shadows the read completely
    assign rd_eff    = rd & ~wr;
    assign in_slots  = (idx_q < IW'(SLOTS));
    assign at_status = (idx_q == IW'(idx_status(SLOTS)));
    assign at_ctrl   = (idx_q == IW'(idx_ctrl(SLOTS)));

    always_comb begin
        idx_rd    = ~a0 & rd_eff;
        slot_rd   = a0 & rd_eff & in_slots;
        slot_wr   = a0 & wr & in_slots;
        status_rd = a0 & rd_eff & at_status;
        status_wr = a0 & wr & at_status;
        ctrl_rd   = a0 & rd_eff & at_ctrl;
        ctrl_wr   = a0 & wr & at_ctrl;

        idx_d = idx_q;
        if (~a0 & wr) begin
            idx_d = din_idx;
        end else if (slot_rd | slot_wr) begin
            idx_d = (idx_q == IW'(SLOTS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign slot = idx_q[$clog2(SLOTS)-1:0];
endmodule

// File: rtl/taito_comm_mailbox.sv
// Two-way CPU mailbox: slot banks per direction, pair-full flags, control regs, IRQ/NMI/reset outputs.
// Reads return one cycle after RD, flag-driven outputs lag by one cycle; no backpressure.
module taito_comm_mailbox
    import taito_comm_pkg::*;
#(
    parameter int DW    = 4,
    parameter int SLOTS = 4,
    parameter int IW    = calc_iw(SLOTS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    taito_comm_mailbox_if.slave  bus,
    input  logic [1:0]           IN,
    output logic                 SLAVE_RST_N,
    output logic                 NMI_N,
    output logic                 M_IRQ,
    output logic                 AMP
);
    localparam int PAIRS = SLOTS / 2;
    localparam int SW    = $clog2(SLOTS);

    logic [IW-1:0] m_idx, s_idx;
    logic [SW-1:0] m_slot, s_slot;
    logic m_idx_rd, m_slot_rd, m_slot_wr, m_status_rd, m_status_wr, m_ctrl_rd, m_ctrl_wr;
    logic s_idx_rd, s_slot_rd, s_slot_wr, s_status_rd, s_status_wr, s_ctrl_rd, s_ctrl_wr;

    logic [DW-1:0]    m2s_q [SLOTS];
    logic [DW-1:0]    m2s_d [SLOTS];
    logic [DW-1:0]    s2m_q [SLOTS];
    logic [DW-1:0]    s2m_d [SLOTS];
    logic [PAIRS-1:0] m2s_full_q, m2s_full_d, s2m_full_q, s2m_full_d;
    logic             srst_q, srst_d, irq_en_q, irq_en_d;
    logic             amp_q, amp_d, nmi_en_q, nmi_en_d;
    logic [DW-1:0]    m_dout_q, m_dout_d, s_dout_q, s_dout_d;
    logic             nmi_n_q, nmi_n_d, m_irq_q, m_irq_d, slave_rst_n_q, slave_rst_n_d;
    logic             sdr;
    logic             m_rd_data, s_rd_data;
    logic [SLOTS-1:0] status;

    // srst_q holds the whole slave domain in reset for as long as it stays set
    assign sdr       = RESET | srst_q;
    assign m_rd_data = bus.M_A0 & bus.M_RD & ~bus.M_WR;
    assign s_rd_data = bus.S_A0 & bus.S_RD & ~bus.S_WR;
    assign status    = {s2m_full_q, m2s_full_q};

    comm_port_index #(.SLOTS(SLOTS), .IW(IW)) u_m_index (
        .clk(CLK), .clr(RESET), .a0(bus.M_A0), .rd(bus.M_RD), .wr(bus.M_WR),
        .din_idx(bus.M_DIN[IW-1:0]), .idx(m_idx), .slot(m_slot),
        .idx_rd(m_idx_rd), .slot_rd(m_slot_rd), .slot_wr(m_slot_wr),
        .status_rd(m_status_rd), .status_wr(m_status_wr),
        .ctrl_rd(m_ctrl_rd), .ctrl_wr(m_ctrl_wr)
    );

    comm_port_index #(.SLOTS(SLOTS), .IW(IW)) u_s_index (
        .clk(CLK), .clr(sdr), .a0(bus.S_A0), .rd(bus.S_RD), .wr(bus.S_WR),
        .din_idx(bus.S_DIN[IW-1:0]), .idx(s_idx), .slot(s_slot),
        .idx_rd(s_idx_rd), .slot_rd(s_slot_rd), .slot_wr(s_slot_wr),
        .status_rd(s_status_rd), .status_wr(s_status_wr),
        .ctrl_rd(s_ctrl_rd), .ctrl_wr(s_ctrl_wr)
    );

    always_comb begin
        m2s_d = m2s_q;
        s2m_d = s2m_q;
        if (m_slot_wr) m2s_d[m_slot] = bus.M_DIN;
        if (s_slot_wr) s2m_d[s_slot] = bus.S_DIN;

        // Clear first so a same-cycle set on the pair wins
        m2s_full_d = m2s_full_q;
        s2m_full_d = s2m_full_q;
        for (int k = 0; k < PAIRS; k++) begin
            if (s_slot_rd && s_slot == SW'(2 * k + 1)) m2s_full_d[k] = 1'b0;
            if (m_slot_wr && m_slot == SW'(2 * k + 1)) m2s_full_d[k] = 1'b1;
            if (m_slot_rd && m_slot == SW'(2 * k + 1)) s2m_full_d[k] = 1'b0;
            if (s_slot_wr && s_slot == SW'(2 * k + 1)) s2m_full_d[k] = 1'b1;
        end

        srst_d   = m_status_wr ? bus.M_DIN[CTRL_SRST_BIT]  : srst_q;
        irq_en_d = m_ctrl_wr   ? bus.M_DIN[CTRL_IRQEN_BIT] : irq_en_q;
        amp_d    = s_status_wr ? bus.S_DIN[CTRL_AMP_BIT]   : amp_q;
        nmi_en_d = s_ctrl_wr   ? bus.S_DIN[CTRL_NMIEN_BIT] : nmi_en_q;

        nmi_n_d       = ~(nmi_en_q & |m2s_full_q);
        m_irq_d       = irq_en_q & |s2m_full_q;
        slave_rst_n_d = ~srst_q;
    end

    always_comb begin
        m_dout_d = m_dout_q;
        if (m_idx_rd)         m_dout_d = DW'(m_idx);
        else if (m_slot_rd)   m_dout_d = s2m_q[m_slot];
        else if (m_status_rd) m_dout_d = DW'(status);
        else if (m_ctrl_rd)   m_dout_d = DW'(irq_en_q);
        else if (m_rd_data)   m_dout_d = '0;

        s_dout_d = s_dout_q;
        if (s_idx_rd)         s_dout_d = DW'(s_idx);
        else if (s_slot_rd)   s_dout_d = m2s_q[s_slot];
        else if (s_status_rd) s_dout_d = DW'(status);
        else if (s_ctrl_rd)   s_dout_d = DW'(IN);
        else if (s_rd_data)   s_dout_d = '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < SLOTS; k++) begin
                m2s_q[k] <= '0;
                s2m_q[k] <= '0;
            end
            srst_q        <= 1'b0;
            irq_en_q      <= 1'b0;
            m_dout_q      <= '0;
            s_dout_q      <= '0;
            nmi_n_q       <= 1'b1;
            m_irq_q       <= 1'b0;
            slave_rst_n_q <= 1'b0;
        end else begin
            m2s_q         <= m2s_d;
            s2m_q         <= s2m_d;
            srst_q        <= srst_d;
            irq_en_q      <= irq_en_d;
            m_dout_q      <= m_dout_d;
            s_dout_q      <= s_dout_d;
            nmi_n_q       <= nmi_n_d;
            m_irq_q       <= m_irq_d;
            slave_rst_n_q <= slave_rst_n_d;
        end
    end

    always_ff @(posedge CLK or posedge sdr) begin
        if (sdr) begin
            m2s_full_q <= '0;
            s2m_full_q <= '0;
            amp_q      <= 1'b0;
            nmi_en_q   <= 1'b0;
        end else begin
            m2s_full_q <= m2s_full_d;
            s2m_full_q <= s2m_full_d;
            amp_q      <= amp_d;
            nmi_en_q   <= nmi_en_d;
        end
    end

    assign bus.M_DOUT  = m_dout_q;
    assign bus.S_DOUT  = s_dout_q;
    assign SLAVE_RST_N = slave_rst_n_q;
    assign NMI_N       = nmi_n_q;
    assign M_IRQ       = m_irq_q;
    assign AMP         = amp_q;
endmodule
